// File: rtl/ldtu_rx_pkg.sv
// Shared encodings and widths for the LiTE-DTU serial lane receiver.
package ldtu_rx_pkg;

    localparam int unsigned Nbits_32 = 32;
    localparam int unsigned BitCntW  = 5;
    localparam int unsigned FillW    = 6;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rxState_t;

endpackage

// File: rtl/ldtu_rx_word_shifter.sv
// MSB-first serial-to-parallel shifter with fill tracking and a free-running
// 32-bit word boundary counter that the FSM can re-phase.
module ldtu_rx_word_shifter
    import ldtu_rx_pkg::*;
(
    input  logic                clock,
    input  logic                rst,
    input  logic                SerIn,
    input  logic                clrFill,
    input  logic                clrBit,
    output logic [Nbits_32-1:0] sr,
    output logic                filled,
    output logic                boundary
);

    logic [FillW-1:0]   fillCnt;
    logic [BitCntW-1:0] bitCnt;

    always_ff @(posedge clock) begin
        if (rst) begin
            sr      <= '0;
            fillCnt <= '0;
            bitCnt  <= '0;
        end else begin
            sr <= {sr[Nbits_32-2:0], SerIn};
            if (clrFill) begin
                fillCnt <= '0;
            end else if (!filled) begin
                fillCnt <= fillCnt + FillW'(1);
            end
            // Clearing on a hunt match puts the next boundary 32 bits later.
            if (clrBit) begin
                bitCnt <= '0;
            end else begin
                bitCnt <= bitCnt + BitCntW'(1);
            end
        end
    end

    assign filled   = (fillCnt == FillW'(Nbits_32));
    assign boundary = (bitCnt == '1);

endmodule

// File: rtl/ldtu_ser_lane_receiver.sv
// Receive end of one LiTE-DTU serializer lane: hunts for the synch pattern, locks, delivers words.
// Build option: define LDTU_RX_ERRCNT_EN to implement the saturating ErrCnt counter.
module ldtu_ser_lane_receiver
    import ldtu_rx_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2,
    parameter int unsigned ERR_BITS     = 8
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                SerIn,
    input  logic [Nbits_32-1:0] synch_pattern,
    input  logic                sync_mode,
    input  logic                realign,
    output logic [Nbits_32-1:0] DataOut,
    output logic                DataValid,
    output logic                Locked,
    output logic [ERR_BITS-1:0] ErrCnt
);

    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW  = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MatchW-1:0] LockLim   = MatchW'(LOCK_COUNT);
    localparam logic [MissW-1:0]  UnlockLim = MissW'(UNLOCK_COUNT);

    rxState_t            stateQ, stateD;
    logic [MatchW-1:0]   matchCntQ, matchCntD;
    logic [MissW-1:0]    missCntQ, missCntD;
    logic [Nbits_32-1:0] sr;
    logic                filled, boundary, clrBit, patMatch, dataValidD;

    ldtu_rx_word_shifter u_shifter (
        .clock    (clock),
        .rst      (rst),
        .SerIn    (SerIn),
        .clrFill  (realign),
        .clrBit   (clrBit),
        .sr       (sr),
        .filled   (filled),
        .boundary (boundary)
    );

    assign patMatch = (sr == synch_pattern);

    always_ff @(posedge clock) begin
        if (rst) begin
            stateQ    <= HUNT;
            matchCntQ <= '0;
            missCntQ  <= '0;
        end else begin
            stateQ    <= stateD;
            matchCntQ <= matchCntD;
            missCntQ  <= missCntD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        matchCntD = matchCntQ;
        missCntD  = missCntQ;
        clrBit    = 1'b0;
        if (realign) begin
            stateD    = HUNT;
            matchCntD = '0;
            missCntD  = '0;
        end else begin
            unique case (stateQ)
                HUNT: begin
                    if (filled && patMatch) begin
                        clrBit    = 1'b1;
                        matchCntD = MatchW'(1);
                        missCntD  = '0;
                        stateD    = (MatchW'(1) >= LockLim) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (patMatch) begin
                            matchCntD = matchCntQ + MatchW'(1);
                            if (matchCntD >= LockLim) begin
                                stateD = LOCKED;
                            end
                        end else begin
                            // Fill is kept: sr already holds 32 valid bits to hunt on.
                            stateD    = HUNT;
                            matchCntD = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary && sync_mode) begin
                        if (patMatch) begin
                            missCntD = '0;
                        end else begin
                            missCntD = missCntQ + MissW'(1);
                            if (missCntD >= UnlockLim) begin
                                stateD    = HUNT;
                                matchCntD = '0;
                                missCntD  = '0;
                            end
                        end
                    end
                end
                default: stateD = HUNT;
            endcase
        end
    end

    always_comb begin
        dataValidD = !realign && (stateQ == LOCKED) && boundary;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            Locked    <= 1'b0;
        end else begin
            DataValid <= dataValidD;
            if (dataValidD) begin
                DataOut <= sr;
            end
            Locked <= (stateD == LOCKED);
        end
    end

`ifdef LDTU_RX_ERRCNT_EN
    logic                errInc;
    logic [ERR_BITS-1:0] errCntQ;

    assign errInc = dataValidD && sync_mode && !patMatch;

    always_ff @(posedge clock) begin
        if (rst) begin
            errCntQ <= '0;
        end else if (errInc && (errCntQ != '1)) begin
            errCntQ <= errCntQ + ERR_BITS'(1);
        end
    end

    assign ErrCnt = errCntQ;
`else
    assign ErrCnt = '0;
`endif

endmodule
